// File: rtl/user_wb_pkg.sv
// Shared types and helpers for the user-area Wishbone fan-out bridge.
package user_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    // Width of a slave index; a single slave still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/user_wb_if.sv
// Bundle of the upstream management Wishbone port and the fanned-out peripheral bus.
interface user_wb_if #(
    parameter int unsigned N_SLV = 4,
    parameter int unsigned DAT_W = 32,
    parameter int unsigned ADR_W = 32
) ();
    logic                     wbs_cyc_i;
    logic                     wbs_stb_i;
    logic                     wbs_we_i;
    logic [DAT_W/8-1:0]       wbs_sel_i;
    logic [ADR_W-1:0]         wbs_adr_i;
    logic [DAT_W-1:0]         wbs_dat_i;
    logic                     wbs_ack_o;
    logic [DAT_W-1:0]         wbs_dat_o;
    logic [N_SLV-1:0]         m_cyc_o;
    logic [N_SLV-1:0]         m_stb_o;
    logic                     m_we_o;
    logic [DAT_W/8-1:0]       m_sel_o;
    logic [ADR_W-1:0]         m_adr_o;
    logic [DAT_W-1:0]         m_dat_o;
    logic [N_SLV*DAT_W-1:0]   m_dat_i;
    logic [N_SLV-1:0]         m_ack_i;
    logic                     err_o;
    logic [ADR_W-1:0]         err_adr_o;

    // Crossbar view: slave of the management bus, master of the peripherals.
    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  m_dat_i, m_ack_i,
        output wbs_ack_o, wbs_dat_o,
        output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        output err_o, err_adr_o
    );

    // Environment view: management master plus the peripherals.
    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output m_dat_i, m_ack_i,
        input  wbs_ack_o, wbs_dat_o,
        input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
        input  err_o, err_adr_o
    );
endinterface

// File: rtl/user_wb_timeout.sv
// Loadable down-counter; expired_o flags the enabled cycle in which the count has reached zero.
module user_wb_timeout #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Clear beats load, load beats decrement; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {CNT_W{1'b0}})) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign expired_o = en_i && (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/user_wb_xbar.sv
// Wishbone fan-out bridge from the Caravel management port to N_SLV user peripherals.
// Optional ACTIVE-state timeout is compiled in with USER_WB_TIMEOUT_EN.
module user_wb_xbar
    import user_wb_pkg::*;
#(
    parameter int unsigned N_SLV       = 4,
    parameter int unsigned DAT_W       = 32,
    parameter int unsigned ADR_W       = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned SPAN_LOG2   = 20,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_DATA    = DEF_ERR_DATA
) (
    input  logic     wb_clk_i,
    input  logic     wb_rst_ni,
    user_wb_if.slave bus
);
    localparam int unsigned      IDX_W    = idx_width(N_SLV);
    localparam int unsigned      SEL_W    = DAT_W / 8;
    localparam logic [ADR_W-1:0] BASE_A   = ADR_W'(BASE_ADDR);
    localparam logic [ADR_W-1:0] OFF_MASK = ~({ADR_W{1'b1}} << SPAN_LOG2);
    localparam logic [ADR_W-1:0] NSLV_A   = ADR_W'(N_SLV);
    localparam logic [DAT_W-1:0] ERR_D    = DAT_W'(ERR_DATA);

    state_e             state_q, state_d;
    logic [N_SLV-1:0]   cyc_q, cyc_d;
    logic               ack_q, ack_d;
    logic [DAT_W-1:0]   rdat_q, rdat_d;
    logic               err_q, err_d;
    logic [ADR_W-1:0]   err_adr_q, err_adr_d;
    logic               we_q;
    logic [SEL_W-1:0]   sel_q;
    logic [ADR_W-1:0]   adr_off_q;
    logic [ADR_W-1:0]   adr_full_q;
    logic [DAT_W-1:0]   wdat_q;
    logic [IDX_W-1:0]   idx_q;

    logic [ADR_W-1:0]   rel_s;
    logic [ADR_W-1:0]   win_s;
    logic               hit_s;
    logic [IDX_W-1:0]   dec_idx_s;
    logic [N_SLV-1:0]   dec_oh_s;
    logic               sel_ack_s;
    logic [DAT_W-1:0]   sel_dat_s;
    logic               lat_s;
    logic               req_s;
    logic               tmo_load_s;
    logic               tmo_exp_s;

    assign req_s     = bus.wbs_cyc_i && bus.wbs_stb_i;
    assign rel_s     = bus.wbs_adr_i - BASE_A;
    assign win_s     = rel_s >> SPAN_LOG2;
    assign hit_s     = (bus.wbs_adr_i >= BASE_A) && (win_s < NSLV_A);
    assign dec_idx_s = win_s[IDX_W-1:0];

    // Address decode to a one-hot slave select and mux of the selected slave's response.
    always_comb begin
        dec_oh_s  = {N_SLV{1'b0}};
        sel_ack_s = 1'b0;
        sel_dat_s = {DAT_W{1'b0}};
        for (int k = 0; k < N_SLV; k++) begin
            dec_oh_s[k] = (dec_idx_s == IDX_W'(k));
            sel_ack_s   = sel_ack_s | (bus.m_ack_i[k] & (idx_q == IDX_W'(k)));
            sel_dat_s   = sel_dat_s |
                          (bus.m_dat_i[k*DAT_W +: DAT_W] & {DAT_W{idx_q == IDX_W'(k)}});
        end
    end

`ifdef USER_WB_TIMEOUT_EN
    user_wb_timeout #(
        .CNT_W (16)
    ) u_timeout (
        .clk_i      (wb_clk_i),
        .rst_ni     (wb_rst_ni),
        .clr_i      (state_q == ST_RESP),
        .load_i     (tmo_load_s),
        .load_val_i (16'(TIMEOUT_CYC - 1)),
        .en_i       (state_q == ST_ACTIVE),
        .expired_o  (tmo_exp_s)
    );
`else
    assign tmo_exp_s = 1'b0;
`endif

    // Next-state and registered-output values; abort by a dropped cycle has top priority in ACTIVE.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        ack_d      = 1'b0;
        rdat_d     = {DAT_W{1'b0}};
        err_d      = 1'b0;
        err_adr_d  = err_adr_q;
        lat_s      = 1'b0;
        tmo_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    lat_s = 1'b1;
                    if (hit_s) begin
                        state_d    = ST_ACTIVE;
                        cyc_d      = dec_oh_s;
                        tmo_load_s = 1'b1;
                    end else begin
                        state_d   = ST_RESP;
                        ack_d     = 1'b1;
                        rdat_d    = ERR_D;
                        err_d     = 1'b1;
                        err_adr_d = bus.wbs_adr_i;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (!bus.wbs_cyc_i) begin
                    state_d = ST_IDLE;
                    cyc_d   = {N_SLV{1'b0}};
                end else if (sel_ack_s) begin
                    state_d = ST_RESP;
                    cyc_d   = {N_SLV{1'b0}};
                    ack_d   = 1'b1;
                    rdat_d  = sel_dat_s;
                end else if (tmo_exp_s) begin
                    state_d   = ST_RESP;
                    cyc_d     = {N_SLV{1'b0}};
                    ack_d     = 1'b1;
                    rdat_d    = ERR_D;
                    err_d     = 1'b1;
                    err_adr_d = adr_full_q;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                cyc_d   = {N_SLV{1'b0}};
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = {N_SLV{1'b0}};
            end
        endcase
    end

    // State, response and error registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= ST_IDLE;
            cyc_q     <= {N_SLV{1'b0}};
            ack_q     <= 1'b0;
            rdat_q    <= {DAT_W{1'b0}};
            err_q     <= 1'b0;
            err_adr_q <= {ADR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            ack_q     <= ack_d;
            rdat_q    <= rdat_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
        end
    end

    // Request payload captured on acceptance and held for the whole downstream cycle.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            we_q       <= 1'b0;
            sel_q      <= {SEL_W{1'b0}};
            adr_off_q  <= {ADR_W{1'b0}};
            adr_full_q <= {ADR_W{1'b0}};
            wdat_q     <= {DAT_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
        end else if (lat_s) begin
            we_q       <= bus.wbs_we_i;
            sel_q      <= bus.wbs_sel_i;
            adr_off_q  <= rel_s & OFF_MASK;
            adr_full_q <= bus.wbs_adr_i;
            wdat_q     <= bus.wbs_dat_i;
            idx_q      <= dec_idx_s;
        end else begin
            we_q       <= we_q;
            sel_q      <= sel_q;
            adr_off_q  <= adr_off_q;
            adr_full_q <= adr_full_q;
            wdat_q     <= wdat_q;
            idx_q      <= idx_q;
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = rdat_q;
    assign bus.m_cyc_o   = cyc_q;
    assign bus.m_stb_o   = cyc_q;
    assign bus.m_we_o    = we_q;
    assign bus.m_sel_o   = sel_q;
    assign bus.m_adr_o   = adr_off_q;
    assign bus.m_dat_o   = wdat_q;
    assign bus.err_o     = err_q;
    assign bus.err_adr_o = err_adr_q;

endmodule
